bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 38 +++
 rtl/bus_arbiter_rr_arb2.sv | 38 +++
 rtl/bus_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared definitions for the I-cache / D-cache bus arbiter:
//   - arbiter FSM state enum
//   - owner / grant encoding (bit 0 = I-cache, bit 1 = D-cache)
//   - index of the write flag inside a request tag
//   - default number of data beats per transaction
//   - helper that sizes the beat counter
package bus_arbiter_pkg;

  // One cache line per transaction.
  localparam int BEATS_DEFAULT = 8;

  // Request tag bit that marks a write transaction.
  localparam int WR_BIT = 0;

  // Client indices; they also give the bit position of each client in the
  // owner / grant vectors.
  localparam int CLIENT_IC = 0;
  localparam int CLIENT_DC = 1;

  // Owner encoding, one-hot per client so owner bits double as selects.
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_IC   = 2'b01;
  localparam logic [1:0] OWNER_DC   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } arb_state_t;

  // Beat counter width; a single-beat line still needs a 1-bit counter.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin picker with a last-grant register.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   enable     : the caller is issuing a grant this cycle (arbiter idle)
//   req[1:0]   : request vector, bit 0 = I-cache, bit 1 = D-cache
//   grant[1:0] : combinational one-hot pick (00 when nobody requests)
// On a tie the client that was not granted most recently wins. After reset
// the I-cache counts as the last grantee, so the D-cache wins the first tie.
module rr_arb2
  import bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // 1 when the D-cache received the most recent grant.
  logic last_dc_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_dc_reg ? OWNER_IC : OWNER_DC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dc_reg <= 1'b0;
    end else if (enable && (req != 2'b00)) begin
      last_dc_reg <= grant[CLIENT_DC];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Arbitrates one shared cache-line bus between an I-cache and a D-cache.
// One transaction is in flight at a time: an address beat (ADDR), then either
// BEATS write-data beats (WDATA) or BEATS read-response beats (RDATA).
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   ic_*/dc_* reqcyc, req, reqtag     : client request beat (valid/data/tag)
//   ic_*/dc_* reqack                  : request beat accepted by the bus
//   ic_*/dc_* respcyc, resp, resptag  : response beat routed to that client
//   ic_*/dc_* respack                 : client accepts the response beat
//   bus_reqcyc, bus_req, bus_reqtag   : request beat presented to the bus
//   bus_reqack                        : bus accepts the request beat
//   bus_respcyc, bus_resp, bus_resptag: response beat from the bus
//   bus_respack                       : owner accepts the response beat
//   owner                             : 00 none, 01 I-cache, 10 D-cache
// The request/response paths are combinational pass-throughs selected by the
// registered owner; every output is forced to zero while reset is high.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = BEATS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      ic_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] ic_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
  output logic                      ic_reqack,
  output logic                      ic_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ic_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,
  input  logic                      ic_respack,

  input  logic                      dc_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] dc_req,
  input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
  output logic                      dc_reqack,
  output logic                      dc_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dc_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,
  input  logic                      dc_respack,

  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,

  output logic [1:0]                owner
);

  localparam int CNT_W = beat_cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // ---------------------------------------------------------------------
  // Client-side signals gathered into arrays indexed by CLIENT_IC/CLIENT_DC
  // ---------------------------------------------------------------------
  logic [1:0]                cl_reqcyc;
  logic [1:0]                cl_respack;
  logic [BUS_DATA_WIDTH-1:0] cl_req    [2];
  logic [BUS_TAG_WIDTH-1:0]  cl_reqtag [2];
  logic [1:0]                cl_reqack;
  logic [1:0]                cl_respcyc;
  logic [BUS_DATA_WIDTH-1:0] cl_resp    [2];
  logic [BUS_TAG_WIDTH-1:0]  cl_resptag [2];

  assign cl_reqcyc[CLIENT_IC]  = ic_reqcyc;
  assign cl_reqcyc[CLIENT_DC]  = dc_reqcyc;
  assign cl_respack[CLIENT_IC] = ic_respack;
  assign cl_respack[CLIENT_DC] = dc_respack;
  assign cl_req[CLIENT_IC]     = ic_req;
  assign cl_req[CLIENT_DC]     = dc_req;
  assign cl_reqtag[CLIENT_IC]  = ic_reqtag;
  assign cl_reqtag[CLIENT_DC]  = dc_reqtag;

  assign ic_reqack  = cl_reqack[CLIENT_IC];
  assign dc_reqack  = cl_reqack[CLIENT_DC];
  assign ic_respcyc = cl_respcyc[CLIENT_IC];
  assign dc_respcyc = cl_respcyc[CLIENT_DC];
  assign ic_resp    = cl_resp[CLIENT_IC];
  assign dc_resp    = cl_resp[CLIENT_DC];
  assign ic_resptag = cl_resptag[CLIENT_IC];
  assign dc_resptag = cl_resptag[CLIENT_DC];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  arb_state_t       state_reg;
  logic [1:0]       owner_reg;
  logic [CNT_W-1:0] count_reg;

  // ---------------------------------------------------------------------
  // Round-robin pick, only consulted while idle
  // ---------------------------------------------------------------------
  logic       arb_enable;
  logic [1:0] arb_grant;

  assign arb_enable = (state_reg == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .enable (arb_enable),
    .req    (cl_reqcyc),
    .grant  (arb_grant)
  );

  // ---------------------------------------------------------------------
  // Owner's request-side signals
  // ---------------------------------------------------------------------
  logic                      sel_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] sel_req;
  logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;
  logic                      sel_respack;

  always_comb begin
    sel_reqcyc  = 1'b0;
    sel_req     = '0;
    sel_reqtag  = '0;
    sel_respack = 1'b0;
    case (owner_reg)
      OWNER_IC: begin
        sel_reqcyc  = cl_reqcyc[CLIENT_IC];
        sel_req     = cl_req[CLIENT_IC];
        sel_reqtag  = cl_reqtag[CLIENT_IC];
        sel_respack = cl_respack[CLIENT_IC];
      end
      OWNER_DC: begin
        sel_reqcyc  = cl_reqcyc[CLIENT_DC];
        sel_req     = cl_req[CLIENT_DC];
        sel_reqtag  = cl_reqtag[CLIENT_DC];
        sel_respack = cl_respack[CLIENT_DC];
      end
      default: ;
    endcase
  end

  // Phase qualifiers; reset blanks every path so that nothing leaks onto
  // the bus while an in-flight transaction is being abandoned.
  logic req_phase;
  logic resp_phase;

  assign req_phase  = !reset && ((state_reg == ST_ADDR) || (state_reg == ST_WDATA));
  assign resp_phase = !reset && (state_reg == ST_RDATA);

  assign bus_reqcyc  = req_phase && sel_reqcyc;
  assign bus_req     = req_phase ? sel_req : '0;
  assign bus_reqtag  = req_phase ? sel_reqtag : '0;
  // bus_respcyc outside RDATA is never acknowledged.
  assign bus_respack = resp_phase && sel_respack;
  assign owner       = reset ? OWNER_NONE : owner_reg;

  // ---------------------------------------------------------------------
  // Per-client return paths: only the owner sees acks or response beats
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      logic is_owner;
      assign is_owner        = owner_reg[gi];
      assign cl_reqack[gi]   = req_phase && is_owner && bus_reqack;
      assign cl_respcyc[gi]  = resp_phase && is_owner && bus_respcyc;
      assign cl_resp[gi]     = (resp_phase && is_owner) ? bus_resp : '0;
      assign cl_resptag[gi]  = (resp_phase && is_owner) ? bus_resptag : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWNER_NONE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          count_reg <= '0;
          // Grant encoding equals owner encoding.
          if (arb_grant != 2'b00) begin
            owner_reg <= arb_grant;
            state_reg <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (!sel_reqcyc) begin
            // Owner withdrew before the address was taken: release the bus
            // without having consumed a bus beat.
            state_reg <= ST_IDLE;
            owner_reg <= OWNER_NONE;
          end else if (bus_reqack) begin
            count_reg <= '0;
            state_reg <= sel_reqtag[WR_BIT] ? ST_WDATA : ST_RDATA;
          end
        end

        ST_WDATA: begin
          if (sel_reqcyc && bus_reqack) begin
            if (count_reg == LAST_BEAT) begin
              state_reg <= ST_IDLE;
              owner_reg <= OWNER_NONE;
              count_reg <= '0;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end

        ST_RDATA: begin
          if (bus_respcyc && sel_respack) begin
            if (count_reg == LAST_BEAT) begin
              state_reg <= ST_IDLE;
              owner_reg <= OWNER_NONE;
              count_reg <= '0;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          owner_reg <= OWNER_NONE;
          count_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
// tb_bus_arbiter
// Directed scenarios plus randomized transaction rounds. Expected grant order
// comes from a transaction-level round-robin model ("who was served last");
// expected data comes from the values the bench itself drives.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_reqcyc, dc_reqcyc, ic_respack, dc_respack;
  logic [DW-1:0] ic_req, dc_req, bus_resp;
  logic [TW-1:0] ic_reqtag, dc_reqtag, bus_resptag;
  logic          bus_reqack, bus_respcyc;
  logic          ic_reqack, dc_reqack, ic_respcyc, dc_respcyc;
  logic [DW-1:0] ic_resp, dc_resp, bus_req;
  logic [TW-1:0] ic_resptag, dc_resptag, bus_reqtag;
  logic          bus_reqcyc, bus_respack;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;
  bit model_last_dc;  // reference model: D-cache was the most recent grantee

  always #5 clk = ~clk;

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB)) dut (
    .clk(clk), .reset(reset),
    .ic_reqcyc(ic_reqcyc), .ic_req(ic_req), .ic_reqtag(ic_reqtag), .ic_reqack(ic_reqack),
    .ic_respcyc(ic_respcyc), .ic_resp(ic_resp), .ic_resptag(ic_resptag), .ic_respack(ic_respack),
    .dc_reqcyc(dc_reqcyc), .dc_req(dc_req), .dc_reqtag(dc_reqtag), .dc_reqack(dc_reqack),
    .dc_respcyc(dc_respcyc), .dc_resp(dc_resp), .dc_resptag(dc_resptag), .dc_respack(dc_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .owner(owner)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int c, input logic cyc, input logic [DW-1:0] d, input logic [TW-1:0] t);
    if (c == 0) begin ic_reqcyc = cyc; ic_req = d; ic_reqtag = t; end
    else        begin dc_reqcyc = cyc; dc_req = d; dc_reqtag = t; end
  endtask

  task automatic drive_respack(input int c, input logic v);
    if (c == 0) ic_respack = v; else dc_respack = v;
  endtask

  task automatic quiet_inputs();
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    ic_respack = 1'b0; dc_respack = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
  endtask

  function automatic logic get_reqack(input int c);
    return (c == 0) ? ic_reqack : dc_reqack;
  endfunction
  function automatic logic get_respcyc(input int c);
    return (c == 0) ? ic_respcyc : dc_respcyc;
  endfunction
  function automatic logic [DW-1:0] get_resp(input int c);
    return (c == 0) ? ic_resp : dc_resp;
  endfunction
  function automatic logic [TW-1:0] get_resptag(input int c);
    return (c == 0) ? ic_resptag : dc_resptag;
  endfunction
  function automatic logic [1:0] enc(input int c);
    return (c == 0) ? 2'b01 : 2'b10;
  endfunction

  // Round-robin reference: lone requester wins; on a tie the client not
  // served last wins. Returns 0 for I-cache, 1 for D-cache.
  task automatic model_grant(input bit want_i, input bit want_d, output int c);
    if (want_i && want_d) c = model_last_dc ? 0 : 1;
    else                  c = want_d ? 1 : 0;
    model_last_dc = (c == 1);
  endtask

  // Runs one transaction for client c, entered in the cycle where c should
  // already own the bus (ADDR). Leaves the bench in the following IDLE cycle.
  task automatic run_txn(input int c, input bit wr, input logic [DW-1:0] addr,
                         input int addr_wait, input int stall_beat, input int stall_len,
                         input bit spurious, output int acks, output int beats);
    int o;
    int n;
    logic [TW-1:0] tag;
    logic [TW-1:0] rtag;
    logic [DW-1:0] d;
    logic ack;
    o = 1 - c;
    acks = 0;
    beats = 0;
    tag = TW'($urandom);
    tag[WR_BIT] = wr;
    drive_req(c, 1'b1, addr, tag);
    // address beat
    for (int w = 0; w <= addr_wait; w++) begin
      ack = (w == addr_wait);
      bus_reqack = ack;
      bus_respcyc = spurious; bus_resp = {$urandom, $urandom};
      drive_respack(c, spurious); drive_respack(o, spurious);
      #1;
      total++; if (owner !== enc(c)) begin bad++; $display("FAIL addr_owner: got %b need %b", owner, enc(c)); end
      total++; if (bus_reqcyc !== 1'b1) begin bad++; $display("FAIL addr_reqcyc: got %b need 1", bus_reqcyc); end
      total++; if (bus_req !== addr) begin bad++; $display("FAIL addr_req: got %h need %h", bus_req, addr); end
      total++; if (bus_reqtag !== tag) begin bad++; $display("FAIL addr_tag: got %h need %h", bus_reqtag, tag); end
      total++; if (get_reqack(c) !== ack) begin bad++; $display("FAIL addr_ack: got %b need %b", get_reqack(c), ack); end
      total++; if (get_reqack(o) !== 1'b0) begin bad++; $display("FAIL addr_other_ack: got %b need 0", get_reqack(o)); end
      total++; if ({bus_respack, ic_respcyc, dc_respcyc} !== 3'b000) begin bad++;
        $display("FAIL addr_resp_ignored: got %b need 000", {bus_respack, ic_respcyc, dc_respcyc}); end
      if (ack) acks++;
      step();
    end
    bus_reqack = 1'b0;
    if (wr) begin
      for (int b = 0; b < NB; b++) begin
        d = {$urandom, $urandom};
        drive_req(c, 1'b1, d, tag);
        n = (b == stall_beat) ? stall_len : 0;
        for (int s = 0; s <= n; s++) begin
          ack = (s == n);
          bus_reqack = ack;
          bus_respcyc = spurious; bus_resp = {$urandom, $urandom};
          drive_respack(c, spurious); drive_respack(o, spurious);
          #1;
          total++; if (owner !== enc(c)) begin bad++; $display("FAIL wdata_owner: got %b need %b", owner, enc(c)); end
          total++; if (bus_req !== d || bus_reqcyc !== 1'b1) begin bad++;
            $display("FAIL wdata_req: got %b/%h need 1/%h", bus_reqcyc, bus_req, d); end
          total++; if (get_reqack(c) !== ack || get_reqack(o) !== 1'b0) begin bad++;
            $display("FAIL wdata_ack: got %b%b need %b0", get_reqack(c), get_reqack(o), ack); end
          total++; if ({bus_respack, ic_respcyc, dc_respcyc} !== 3'b000) begin bad++;
            $display("FAIL wdata_resp_ignored: got %b need 000", {bus_respack, ic_respcyc, dc_respcyc}); end
          if (ack) acks++;
          step();
        end
      end
    end else begin
      drive_req(c, 1'b0, '0, '0);
      drive_respack(o, 1'b1);  // non-owner acceptance must be ignored
      for (int b = 0; b < NB; b++) begin
        d = {$urandom, $urandom};
        rtag = TW'($urandom);
        n = (b == stall_beat) ? stall_len : 0;
        for (int s = 0; s <= n; s++) begin
          ack = (s == n);
          bus_respcyc = 1'b1; bus_resp = d; bus_resptag = rtag;
          bus_reqack = spurious;
          drive_respack(c, ack);
          #1;
          total++; if (owner !== enc(c)) begin bad++; $display("FAIL rdata_owner: got %b need %b", owner, enc(c)); end
          total++; if (get_respcyc(c) !== 1'b1 || get_resp(c) !== d || get_resptag(c) !== rtag) begin bad++;
            $display("FAIL rdata_route: got %b/%h/%h need 1/%h/%h", get_respcyc(c), get_resp(c), get_resptag(c), d, rtag); end
          total++; if (get_respcyc(o) !== 1'b0 || get_resp(o) !== '0 || get_resptag(o) !== '0) begin bad++;
            $display("FAIL rdata_other: got %b/%h/%h need 0/0/0", get_respcyc(o), get_resp(o), get_resptag(o)); end
          total++; if (bus_respack !== ack) begin bad++; $display("FAIL rdata_respack: got %b need %b", bus_respack, ack); end
          total++; if (bus_reqcyc !== 1'b0 || ic_reqack !== 1'b0 || dc_reqack !== 1'b0) begin bad++;
            $display("FAIL rdata_req_quiet: got %b%b%b need 000", bus_reqcyc, ic_reqack, dc_reqack); end
          if (ack) beats++;
          step();
        end
      end
    end
    // first IDLE cycle: bus released, nobody granted on the return edge
    drive_req(c, 1'b0, '0, '0);
    bus_reqack = 1'b0; bus_respcyc = 1'b0;
    ic_respack = 1'b0; dc_respack = 1'b0;
    #1;
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL end_idle_owner: got %b need 00", owner); end
    total++; if (bus_reqcyc !== 1'b0 || get_reqack(o) !== 1'b0) begin bad++;
      $display("FAIL end_idle_quiet: got %b%b need 00", bus_reqcyc, get_reqack(o)); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    quiet_inputs();
    step(); step();
    ic_reqcyc = 1'b1; dc_reqcyc = 1'b1; bus_reqack = 1'b1; bus_respcyc = 1'b1;
    ic_respack = 1'b1; dc_respack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({owner, bus_reqcyc, bus_respack, ic_reqack, dc_reqack, ic_respcyc, dc_respcyc} !== 8'h00) begin bad++;
        $display("FAIL reset_outputs: got %b need 00000000",
                 {owner, bus_reqcyc, bus_respack, ic_reqack, dc_reqack, ic_respcyc, dc_respcyc}); end
      step();
    end
    reset = 1'b0;
    quiet_inputs();
    model_last_dc = 1'b0;
    #1;
    total++; if ({owner, bus_reqcyc, bus_respack, ic_reqack, dc_reqack, ic_respcyc, dc_respcyc} !== 8'h00) begin bad++;
      $display("FAIL post_reset_outputs: got %b need 00000000",
               {owner, bus_reqcyc, bus_respack, ic_reqack, dc_reqack, ic_respcyc, dc_respcyc}); end
    step();
  endtask

  task automatic test_ic_read();
    int c, acks, beats;
    drive_req(0, 1'b1, 64'h1000, '0);
    #1;
    total++; if (owner !== 2'b00 || bus_reqcyc !== 1'b0) begin bad++;
      $display("FAIL ic_read_idle: got %b/%b need 00/0", owner, bus_reqcyc); end
    step();
    model_grant(1'b1, 1'b0, c);
    run_txn(c, 1'b0, 64'h1000, 0, -1, 0, 1'b0, acks, beats);
    total++; if (acks !== 1) begin bad++; $display("FAIL ic_read_acks: got %0d need 1", acks); end
    total++; if (beats !== NB) begin bad++; $display("FAIL ic_read_beats: got %0d need %0d", beats, NB); end
  endtask

  task automatic test_tie();
    int first, second, third, acks, beats;
    drive_req(0, 1'b1, 64'hA000, '0);
    drive_req(1, 1'b1, 64'hB000, '0);
    #1;
    step();
    model_grant(1'b1, 1'b1, first);
    total++; if (owner !== enc(first)) begin bad++; $display("FAIL tie_first: got %b need %b", owner, enc(first)); end
    run_txn(first, 1'b0, 64'hB000, 1, 2, 1, 1'b0, acks, beats);
    step();
    model_grant(1'b1, 1'b0, second);
    total++; if (owner !== enc(second)) begin bad++; $display("FAIL tie_second: got %b need %b", owner, enc(second)); end
    run_txn(second, 1'b1, 64'hA000, 0, 5, 1, 1'b0, acks, beats);
    drive_req(0, 1'b1, 64'hA040, '0);
    drive_req(1, 1'b1, 64'hB040, '0);
    step();
    model_grant(1'b1, 1'b1, third);
    total++; if (owner !== enc(third)) begin bad++; $display("FAIL tie_third: got %b need %b", owner, enc(third)); end
    run_txn(third, 1'b0, 64'hB040, 0, -1, 0, 1'b0, acks, beats);
    step();
    model_grant(1'b1, 1'b0, second);
    run_txn(second, 1'b0, 64'hA040, 0, -1, 0, 1'b0, acks, beats);
  endtask

  task automatic test_dc_write_stall();
    int c, acks, beats;
    drive_req(1, 1'b1, 64'h2000, '0);
    step();
    model_grant(1'b0, 1'b1, c);
    run_txn(c, 1'b1, 64'h2000, 0, 4, 3, 1'b0, acks, beats);
    total++; if (acks !== NB + 1) begin bad++; $display("FAIL dc_write_acks: got %0d need %0d", acks, NB + 1); end
  endtask

  task automatic test_spurious_resp();
    int c, acks, beats;
    bus_respcyc = 1'b1; bus_resp = 64'hDEAD; ic_respack = 1'b1; dc_respack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({bus_respack, ic_respcyc, dc_respcyc} !== 3'b000) begin bad++;
        $display("FAIL idle_spurious: got %b need 000", {bus_respack, ic_respcyc, dc_respcyc}); end
      step();
    end
    quiet_inputs();
    drive_req(1, 1'b1, 64'h3000, '0);
    step();
    model_grant(1'b0, 1'b1, c);
    run_txn(c, 1'b1, 64'h3000, 1, 0, 0, 1'b1, acks, beats);
  endtask

  task automatic test_reset_mid();
    int c, acks, beats;
    drive_req(0, 1'b1, 64'h4000, '0);
    step();
    model_grant(1'b1, 1'b0, c);
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    drive_req(0, 1'b0, '0, '0);
    for (int b = 0; b < 3; b++) begin
      bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom}; ic_respack = 1'b1;
      step();
    end
    reset = 1'b1;
    bus_reqack = 1'b1; dc_reqcyc = 1'b1;
    #1;
    total++; if ({owner, ic_respcyc, bus_respack, bus_reqcyc, dc_reqack} !== 6'b0) begin bad++;
      $display("FAIL mid_reset_during: got %b need 000000", {owner, ic_respcyc, bus_respack, bus_reqcyc, dc_reqack}); end
    step();
    reset = 1'b0;
    dc_reqcyc = 1'b0;
    model_last_dc = 1'b0;
    #1;
    total++; if ({owner, ic_reqack, dc_reqack, bus_respack, ic_respcyc, bus_reqcyc} !== 7'b0) begin bad++;
      $display("FAIL mid_reset_after: got %b need 0000000", {owner, ic_reqack, dc_reqack, bus_respack, ic_respcyc, bus_reqcyc}); end
    quiet_inputs();
    drive_req(0, 1'b1, 64'h4100, '0);
    step();
    model_grant(1'b1, 1'b0, c);
    run_txn(c, 1'b0, 64'h4100, 0, 6, 2, 1'b0, acks, beats);
    total++; if (beats !== NB) begin bad++; $display("FAIL mid_reset_fresh_beats: got %0d need %0d", beats, NB); end
  endtask

  task automatic test_abort();
    int c, acks, beats;
    drive_req(1, 1'b1, 64'h5000, '0);
    step();
    model_grant(1'b0, 1'b1, c);
    drive_req(1, 1'b0, '0, '0);
    drive_req(0, 1'b1, 64'h6000, '0);
    #1;
    total++; if (owner !== enc(c) || bus_reqcyc !== 1'b0) begin bad++;
      $display("FAIL abort_addr: got %b/%b need %b/0", owner, bus_reqcyc, enc(c)); end
    step();
    total++; if (owner !== 2'b00 || ic_reqack !== 1'b0) begin bad++;
      $display("FAIL abort_idle: got %b/%b need 00/0", owner, ic_reqack); end
    step();
    model_grant(1'b1, 1'b0, c);
    run_txn(c, 1'b0, 64'h6000, 0, -1, 0, 1'b0, acks, beats);
  endtask

  task automatic test_random();
    int pat, first, second, acks, beats;
    bit wr0, wr1;
    logic [DW-1:0] a0, a1;
    for (int r = 0; r < 30; r++) begin
      pat = $urandom_range(1, 3);
      wr0 = 1'($urandom); wr1 = 1'($urandom);
      a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
      drive_req(0, pat[0], a0, '0);
      drive_req(1, pat[1], a1, '0);
      step();
      model_grant(pat[0], pat[1], first);
      run_txn(first, (first == 0) ? wr0 : wr1, (first == 0) ? a0 : a1,
              $urandom_range(0, 2), $urandom_range(0, NB - 1), $urandom_range(0, 3),
              1'($urandom), acks, beats);
      if (pat == 3) begin
        step();
        model_grant(first == 1, first == 0, second);
        run_txn(second, (second == 0) ? wr0 : wr1, (second == 0) ? a0 : a1,
                $urandom_range(0, 2), $urandom_range(0, NB - 1), $urandom_range(0, 3),
                1'($urandom), acks, beats);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_tie();
    test_dc_write_stall();
    test_spurious_resp();
    test_reset_mid();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
